irq_vec_ctrl: RTL and testbench
===============================

IRQ_VEC_CTRL -- requirements
Module: irq_vec_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4: number of interrupt source channels, legal range 1..32.
REQ-002 Parameter ADDR_W, default 32: width of the vector address output.
REQ-003 Parameter VEC_BASE, default 32'h00000000: vector address for channel 0.
REQ-004 Parameter VEC_STRIDE, default 4: byte distance between consecutive channel vectors.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port done, input, NUM_CH: per-channel completion/event lines, level, synchronous to clk.
REQ-008 Port mask, input, NUM_CH: per-channel enable; 1 = channel may raise irq.
REQ-009 Port irq_ack, input, 1: CPU acknowledge of the presented vector.
REQ-010 Port eoi, input, 1: CPU end-of-interrupt; releases the in-service channel.
REQ-011 Port irq, output, 1: interrupt request to CPU, registered.
REQ-012 Port EAddr, output, ADDR_W: vector address of the presented channel, registered.
REQ-013 Port irq_id, output, clog2(NUM_CH) (min 1): index of the presented channel, registered.
REQ-014 Port pending, output, NUM_CH: latched pending bits, registered.

Function
REQ-015 Each channel SHALL register done; a 0->1 transition of done[i] between consecutive rising edges SHALL set pending[i] on that edge.
REQ-016 pending[i] SHALL be set regardless of mask[i]; mask only gates arbitration.
REQ-017 FSM states: IDLE, REQ, SERV; the FSM SHALL leave IDLE only when (pending & mask) is non-zero.
REQ-018 IDLE->REQ: on the edge, the winner SHALL be latched into irq_id, EAddr SHALL be VEC_BASE + irq_id*VEC_STRIDE truncated to ADDR_W bits, and irq SHALL become 1.
REQ-019 Latency: done[i] first sampled high at edge k with FSM in IDLE and mask[i]=1 SHALL yield irq=1 after edge k+1.
REQ-020 In REQ, irq, irq_id and EAddr SHALL hold stable until irq_ack; mask changes in REQ SHALL NOT withdraw the request.
REQ-021 REQ->SERV on irq_ack=1: pending[irq_id] SHALL clear and irq SHALL become 0 on that edge; EAddr and irq_id SHALL hold.
REQ-022 SERV->IDLE on eoi=1; the earliest next irq assertion SHALL be one edge after returning to IDLE.
REQ-023 irq_ack outside REQ and eoi outside SERV SHALL be ignored.
REQ-024 If a new rising edge on done[irq_id] coincides with the clearing irq_ack edge, set SHALL win and pending[irq_id] SHALL remain 1.
REQ-025 Events on any channel during REQ or SERV SHALL accumulate in pending; one event per channel is held (no counting).
REQ-026 Default arbitration SHALL be fixed priority, lowest index wins.

Reset
REQ-027 rst=0 SHALL immediately force FSM=IDLE, irq=0, EAddr=0, irq_id=0, pending=0, registered done=0 and any round-robin pointer=0.
REQ-028 Reset asserted mid-REQ or mid-SERV SHALL discard the in-flight interrupt; no event is retained.
REQ-029 A done line already high at reset release SHALL NOT create a pending event until it goes low and high again.

Configuration
REQ-030 Macro IRQ_VEC_CTRL_RR_EN defined: arbitration SHALL be round-robin; search starts at (last acknowledged irq_id + 1) mod NUM_CH, pointer updated on each irq_ack edge.
REQ-031 Macro IRQ_VEC_CTRL_RR_EN undefined: fixed priority per REQ-026, no pointer logic present.

Verification
REQ-032 NUM_CH=4, done[2] rises at edge k, mask=4'hF -> irq=1 after k+1, irq_id=2, EAddr=32'h00000008; irq_ack -> irq=0, pending[2]=0.
REQ-033 done[3] and done[1] rise on the same edge, fixed priority -> irq_id=1 first; after ack+eoi, irq_id=3, EAddr=32'h0000000C.
REQ-034 mask=4'b1110, done[0] rises -> pending=4'b0001, irq stays 0; mask set to 4'hF -> irq=1, irq_id=0, EAddr=0.
REQ-035 IRQ_VEC_CTRL_RR_EN defined, done[0] and done[1] re-pulsed after every service -> irq_id sequence 0,1,0,1.
REQ-036 rst driven 0 in SERV with pending=4'b0110 -> irq=0, pending=0, EAddr=0 immediately; held-high done lines produce no irq after release.

Source files
------------

// File: rtl/irq_vec_ctrl.sv
// Vectored interrupt controller: per-channel rising-edge capture into pending bits,
// arbitration, and an IDLE/REQ/SERV handshake. `define IRQ_VEC_CTRL_RR_EN for round-robin.
module irq_vec_ctrl #(
  parameter int                NUM_CH     = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = '0,
  parameter int                VEC_STRIDE = 4,
  localparam int               ID_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] done,
  input  logic [NUM_CH-1:0] mask,
  input  logic              irq_ack,
  input  logic              eoi,
  output logic              irq,
  output logic [ADDR_W-1:0] EAddr,
  output logic [ID_W-1:0]   irq_id,
  output logic [NUM_CH-1:0] pending
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              irq_q, irq_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] done_q;
  logic              armed_q;

  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] clr;
  logic [NUM_CH-1:0] req;
  logic [ID_W-1:0]   win_id;
  logic [ADDR_W-1:0] win_addr;
  logic              ack_take;

  function automatic logic [ID_W-1:0] lowest(input logic [NUM_CH-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  assign ack_take = (state_q == ST_REQ) && irq_ack;
  assign req      = pend_q & mask;

  // armed_q suppresses edge detection on the first edge after reset, so a line
  // already high at release must drop and rise again before it counts.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign rise[gi] = armed_q & done[gi] & ~done_q[gi];
      assign clr[gi]  = ack_take & (id_q == ID_W'(gi));
    end
  endgenerate

`ifdef IRQ_VEC_CTRL_RR_EN
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] at_or_above;
  logic [NUM_CH-1:0] req_hi;

  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_rr
      assign at_or_above[gi] = (ID_W'(gi) >= ptr_q);
    end
  endgenerate

  assign req_hi = req & at_or_above;

  // Channels at or above the pointer come first; otherwise wrap to the bottom.
  always_comb begin
    if (|req_hi) win_id = lowest(req_hi);
    else         win_id = lowest(req);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (ack_take) begin
      if (id_q == ID_W'(NUM_CH - 1)) ptr_d = '0;
      else                           ptr_d = id_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end
`else
  assign win_id = lowest(req);
`endif

  assign win_addr = VEC_BASE + ADDR_W'(VEC_STRIDE) * ADDR_W'(win_id);

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          id_d    = win_id;
          addr_d  = win_addr;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_SERV;
          irq_d   = 1'b0;
        end
      end
      ST_SERV: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  // A new event on the channel being acknowledged wins over the clear.
  assign pend_d = (pend_q & ~clr) | rise;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      pend_q  <= '0;
      done_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      done_q  <= done;
      armed_q <= 1'b1;
    end
  end

  assign irq     = irq_q;
  assign irq_id  = id_q;
  assign EAddr   = addr_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_irq_vec_ctrl.sv
// Self-checking bench for irq_vec_ctrl: behavioural model compared every cycle,
// plus directed scenarios with literal expectations (both arbitration builds).
module tb_irq_vec_ctrl;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          STRIDE = 4;
`ifdef IRQ_VEC_CTRL_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic [N-1:0] done;
  logic [N-1:0] mask;
  logic         irq_ack;
  logic         eoi;
  logic         irq;
  logic [31:0]  EAddr;
  logic [1:0]   irq_id;
  logic [N-1:0] pending;

  int n_total = 0;
  int n_pass  = 0;

  irq_vec_ctrl #(
    .NUM_CH    (N),
    .ADDR_W    (32),
    .VEC_BASE  (BASE),
    .VEC_STRIDE(STRIDE)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .done   (done),
    .mask   (mask),
    .irq_ack(irq_ack),
    .eoi    (eoi),
    .irq    (irq),
    .EAddr  (EAddr),
    .irq_id (irq_id),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = nothing presented, 1 = vector presented, 2 = CPU servicing
  int          m_mode;
  int          m_id;
  int          m_ptr;
  logic        m_irq;
  logic [31:0] m_addr;
  logic [N-1:0] m_pend;
  logic [N-1:0] m_prev;
  logic        m_armed;

  function automatic int pick(input logic [N-1:0] cand, input int start);
    for (int k = 0; k < N; k++) begin
      if (cand[(start + k) % N]) return (start + k) % N;
    end
    return 0;
  endfunction

  function automatic logic [N-1:0] onehot(input int id);
    logic [N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) if (k == id) v = 4'b0001 << k;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode  <= 0;
      m_id    <= 0;
      m_ptr   <= 0;
      m_irq   <= 1'b0;
      m_addr  <= '0;
      m_pend  <= '0;
      m_prev  <= '0;
      m_armed <= 1'b0;
    end else begin
      m_prev  <= done;
      m_armed <= 1'b1;
      m_pend  <= (m_pend & ~((m_mode == 1 && irq_ack) ? onehot(m_id) : 4'b0000))
                 | (m_armed ? (done & ~m_prev) : 4'b0000);
      if (m_mode == 0 && (m_pend & mask) != 0) begin
        m_mode <= 1;
        m_irq  <= 1'b1;
        m_id   <= pick(m_pend & mask, RR ? m_ptr : 0);
        m_addr <= BASE + 32'(pick(m_pend & mask, RR ? m_ptr : 0) * STRIDE);
      end else if (m_mode == 1 && irq_ack) begin
        m_mode <= 2;
        m_irq  <= 1'b0;
        m_ptr  <= (m_id + 1) % N;
      end else if (m_mode == 2 && eoi) begin
        m_mode <= 0;
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_irq", 32'(irq), 32'(m_irq));
    check("cyc_irq_id", 32'(irq_id), 32'(m_id));
    check("cyc_eaddr", EAddr, m_addr);
    check("cyc_pending", 32'(pending), 32'(m_pend));
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic serve();
    $display("serve irq_id=%0d EAddr=%h pending=%b", irq_id, EAddr, pending);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
  endtask

  int rr_seq[4] = '{0, 1, 0, 1};
  int fp_seq[4] = '{0, 0, 0, 0};
  int exp_a, exp_b;

  initial begin
    rst = 1'b1; done = '0; mask = 4'hF; irq_ack = 1'b0; eoi = 1'b0;
    #1 rst = 1'b0;
    tick(2);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_eaddr", EAddr, 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    rst = 1'b1;
    tick(2);

    // single event, latency and ack
    done = 4'b0100;
    tick(1);
    done = 4'b0000;
    check("t1_pend_set", 32'(pending), 32'h4);
    check("t1_irq_not_yet", 32'(irq), 32'd0);
    tick(1);
    check("t1_irq", 32'(irq), 32'd1);
    check("t1_id", 32'(irq_id), 32'd2);
    check("t1_eaddr", EAddr, 32'h0000_0008);
    tick(1);
    check("t1_irq_hold", 32'(irq), 32'd1);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    check("t1_ack_irq", 32'(irq), 32'd0);
    check("t1_ack_pend", 32'(pending), 32'h0);
    check("t1_ack_id_hold", 32'(irq_id), 32'd2);
    check("t1_ack_addr_hold", EAddr, 32'h0000_0008);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;

    // two simultaneous events
    exp_a = RR ? 3 : 1;
    exp_b = RR ? 1 : 3;
    done = 4'b1010;
    tick(1);
    done = 4'b0000;
    check("t2_pend", 32'(pending), 32'hA);
    tick(1);
    check("t2_first_id", 32'(irq_id), 32'(exp_a));
    check("t2_first_addr", EAddr, 32'(exp_a * 4));
    serve();
    tick(1);
    check("t2_second_irq", 32'(irq), 32'd1);
    check("t2_second_id", 32'(irq_id), 32'(exp_b));
    check("t2_second_addr", EAddr, 32'(exp_b * 4));
    serve();

    // masked channel latches but does not raise irq
    mask = 4'b1110;
    done = 4'b0001;
    tick(1);
    done = 4'b0000;
    check("t3_pend", 32'(pending), 32'h1);
    tick(3);
    check("t3_masked_irq", 32'(irq), 32'd0);
    mask = 4'hF;
    tick(1);
    check("t3_unmask_irq", 32'(irq), 32'd1);
    check("t3_unmask_id", 32'(irq_id), 32'd0);
    check("t3_unmask_addr", EAddr, 32'd0);
    mask = 4'h0;
    tick(2);
    check("t3_mask_in_req", 32'(irq), 32'd1);
    mask = 4'hF;
    serve();

    // ack/eoi outside their states are ignored
    irq_ack = 1'b1; eoi = 1'b1;
    tick(2);
    irq_ack = 1'b0; eoi = 1'b0;
    check("t4_stray_irq", 32'(irq), 32'd0);
    check("t4_stray_pend", 32'(pending), 32'd0);

    // new event coinciding with ack on the same channel
    done = 4'b0100;
    tick(1);
    done = 4'b0000;
    tick(1);
    check("t4_req_id", 32'(irq_id), 32'd2);
    done = 4'b0100; irq_ack = 1'b1;
    tick(1);
    done = 4'b0000; irq_ack = 1'b0;
    check("t4_setwin_irq", 32'(irq), 32'd0);
    check("t4_setwin_pend", 32'(pending), 32'h4);
    eoi = 1'b1;
    tick(1);
    eoi = 1'b0;
    tick(1);
    check("t4_reraise", 32'(irq), 32'd1);
    check("t4_reraise_id", 32'(irq_id), 32'd2);
    serve();

    // channels 0 and 1 re-pulsed during every service
    done = 4'b0011;
    tick(1);
    done = 4'b0000;
    tick(1);
    for (int i = 0; i < 4; i++) begin
      check("t5_irq", 32'(irq), 32'd1);
      check("t5_id_seq", 32'(irq_id), 32'(RR ? rr_seq[i] : fp_seq[i]));
      $display("serve irq_id=%0d EAddr=%h pending=%b", irq_id, EAddr, pending);
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
      done = 4'b0011;
      tick(1);
      done = 4'b0000;
      eoi = 1'b1;
      tick(1);
      eoi = 1'b0;
      tick(1);
    end

    // reset while a request is presented
    rst = 1'b0;
    #1;
    check("rreq_irq", 32'(irq), 32'd0);
    check("rreq_pend", 32'(pending), 32'd0);
    tick(1);
    rst = 1'b1;
    tick(2);
    check("rreq_after_irq", 32'(irq), 32'd0);

    // reset during service with events pending, done held high across release
    done = 4'b0001;
    tick(1);
    done = 4'b0000;
    tick(1);
    check("t6_req_id", 32'(irq_id), 32'd0);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    done = 4'b0110;
    tick(1);
    check("t6_serv_pend", 32'(pending), 32'h6);
    check("t6_serv_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    #1;
    check("t6_rst_irq", 32'(irq), 32'd0);
    check("t6_rst_pend", 32'(pending), 32'd0);
    check("t6_rst_eaddr", EAddr, 32'd0);
    check("t6_rst_id", 32'(irq_id), 32'd0);
    tick(2);
    rst = 1'b1;
    tick(4);
    check("t6_held_irq", 32'(irq), 32'd0);
    check("t6_held_pend", 32'(pending), 32'd0);
    done = 4'b0000;
    tick(1);
    done = 4'b0100;
    tick(1);
    check("t6_repulse_pend", 32'(pending), 32'h4);
    tick(1);
    check("t6_repulse_irq", 32'(irq), 32'd1);
    check("t6_repulse_addr", EAddr, 32'h0000_0008);
    done = 4'b0000;
    serve();
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
